usb_frame_coder: RTL
====================

// Module: usb_frame_coder
// PURPOSE
//  Transmit-side framer for the USB link: the counterpart of usb_decoder. Takes a message as a byte
//  stream with a last-byte marker and emits a framed, byte-stuffed stream with CRC towards ftdi_ctrl.
//  Sits in the FTDI clock domain between the message builders (status/time/CCW replies) and ftdi_ctrl.
//  Frame format: SOF 0xC0 | escaped payload | escaped CRC8 | EOF 0xC0.
//  Escapes: 0xC0 -> 0xDB 0xDC; 0xDB -> 0xDB 0xDD.
// PARAMETERS
//  MAX_LEN   64    max payload bytes per frame (1..255)
//  CRC_INIT  8'hFF CRC8 seed (poly 0x31, MSB-first, no reflection, no final XOR)
// PORTS
//  clk       in   1  FTDI clock (FCLK_OUT domain); only clock
//  rst       in   1  synchronous reset, active-high
//  in_byte   in   8  payload byte
//  in_vld    in   1  in_byte valid
//  in_last   in   1  in_byte is last payload byte of message (qualified by in_vld)
//  in_rdy    out  1  payload byte consumed on cycle when in_vld & in_rdy
//  tx_byte   out  8  framed byte to ftdi_ctrl
//  tx_vld    out  1  tx_byte valid; held with tx_byte stable until accepted
//  tx_ack    in   1  downstream accepts tx_byte on cycle when tx_vld & tx_ack
//  busy      out  1  high from SOF load until EOF accepted
//  err_len   out  1  1-cycle pulse: frame force-closed at MAX_LEN without in_last
// BEHAVIOUR
//  Reset: state=IDLE, tx_byte=0, tx_vld=0, in_rdy=0, busy=0, err_len=0, crc=CRC_INIT, cnt=0.
//  Single output register. "slot free" = !tx_vld | tx_ack. It is loaded only when the slot is free.
//  States:
//   IDLE   -- in_rdy=0; on in_vld & slot free: load 0xC0, crc<=CRC_INIT, cnt<=0 -> DATA.
//   DATA   -- in_rdy = slot free. On consume:
//              crc updated over raw byte; cnt++.
//              0xC0/0xDB: load 0xDB, save code -> ESC2.
//              Otherwise load byte.
//              Then if in_last or cnt+1==MAX_LEN: -> CRC (or CRC after ESC2).
//   ESC2   -- in_rdy=0; when slot free load 0xDC/0xDD; -> DATA or CRC per saved last flag.
//   CRC    -- when slot free emit final crc (escaped like payload, via CRC_ESC2 if needed) -> EOF.
//   EOF    -- when slot free load 0xC0 -> DONE.
//   DONE   -- when that byte is accepted: tx_vld=0 -> IDLE.
//  Back-to-back frames: the first byte of the next message may wait in IDLE with in_vld high. The next
//   SOF is loaded no earlier than the cycle after DONE exits; EOFs are never shared.
//  busy is high in every state except IDLE.
//  in_rdy is combinational from state and slot free; never high outside DATA.
//  Latency: with tx_ack tied high, SOF appears 1 cycle after in_vld; then 1 byte/cycle throughput.
//   Stuffing inserts one stall cycle per escaped byte.
//  err_len pulses on the cycle the MAX_LEN-th byte is consumed without in_last. That frame is closed
//   normally with CRC and EOF. Following bytes start a new frame.
//  tx_ack while !tx_vld is ignored. in_last without in_vld is ignored.
//  rst mid-frame: immediate return to reset state; a partially sent frame is abandoned (the decoder
//   resyncs on 0xC0).
// TESTING
//  1. Payload 0x31..0x39, last on 0x39, tx_ack=1 -> C0 31 32 33 34 35 36 37 38 39 F7 C0;
//     busy high 12 cycles.
//  2. Payload C0 DB 55 -> C0 DB DC DB DD 55 <crc> C0. CRC per reference model; in_rdy low on the
//     stall cycles.
//  3. Payload forcing CRC == 0xC0 or 0xDB -> CRC byte escaped correctly, EOF follows.
//  4. MAX_LEN=4, 6 bytes, no in_last -> err_len pulse on 4th byte; frame 1 = 4 bytes + CRC + C0;
//     frame 2 = 2 bytes.
//  5. Random tx_ack backpressure, 1000 random frames -> byte-exact match to model, tx_byte stable
//     while tx_vld & !tx_ack.
//  6. rst asserted mid-payload -> next cycle all outputs at reset values; new frame starts with C0,
//     CRC reseeded.

Source files
------------

// File: rtl/usb_frame_coder.sv
// Transmit framer: wraps a payload byte stream as SOF | stuffed payload | stuffed CRC8 | EOF
// and feeds one registered output byte at a time to the FTDI controller.
module usb_frame_coder #(
  parameter int         MAX_LEN  = 64,
  parameter logic [7:0] CRC_INIT = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_byte,
  input  logic       in_vld,
  input  logic       in_last,
  output logic       in_rdy,
  output logic [7:0] tx_byte,
  output logic       tx_vld,
  input  logic       tx_ack,
  output logic       busy,
  output logic       err_len
);

  // Handshakes: a byte moves on a cycle where valid and ready (in_vld/in_rdy, tx_vld/tx_ack)
  // are both high; a valid byte is held stable until that cycle.

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_ESC2,
    S_CRC,
    S_CRC_ESC2,
    S_EOF,
    S_DONE
  } state_t;

  localparam logic [7:0] SOF    = 8'hC0;
  localparam logic [7:0] ESC    = 8'hDB;
  localparam logic [7:0] ESC_C0 = 8'hDC;
  localparam logic [7:0] ESC_DB = 8'hDD;

  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic needs_esc(input logic [7:0] b);
    return (b == SOF) || (b == ESC);
  endfunction

  function automatic logic [7:0] esc_code(input logic [7:0] b);
    return (b == SOF) ? ESC_C0 : ESC_DB;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_vld_q, tx_vld_d;
  logic [7:0] crc_q, crc_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] esc_q, esc_d;
  logic       last_q, last_d;

  logic       slot_free;
  logic       fire;
  logic [8:0] cnt_inc;
  logic       at_max;
  logic       is_last;

  assign slot_free = !tx_vld_q || tx_ack;
  assign in_rdy    = (state_q == S_DATA) && slot_free;
  assign fire      = in_vld && in_rdy;
  assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
  assign at_max    = (cnt_inc == 9'(MAX_LEN));
  assign is_last   = in_last || at_max;
  assign err_len   = fire && at_max && !in_last;

  assign tx_byte = tx_byte_q;
  assign tx_vld  = tx_vld_q;
  assign busy    = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    tx_vld_d  = tx_vld_q && !tx_ack;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    esc_d     = esc_q;
    last_d    = last_q;
    case (state_q)
      S_IDLE: begin
        if (in_vld && slot_free) begin
          tx_byte_d = SOF;
          tx_vld_d  = 1'b1;
          crc_d     = CRC_INIT;
          cnt_d     = 8'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (fire) begin
          crc_d    = crc8_next(crc_q, in_byte);
          cnt_d    = cnt_inc[7:0];
          tx_vld_d = 1'b1;
          if (needs_esc(in_byte)) begin
            tx_byte_d = ESC;
            esc_d     = esc_code(in_byte);
            last_d    = is_last;
            state_d   = S_ESC2;
          end else begin
            tx_byte_d = in_byte;
            state_d   = is_last ? S_CRC : S_DATA;
          end
        end
      end
      S_ESC2: begin
        if (slot_free) begin
          tx_byte_d = esc_q;
          tx_vld_d  = 1'b1;
          state_d   = last_q ? S_CRC : S_DATA;
        end
      end
      S_CRC: begin
        if (slot_free) begin
          tx_vld_d = 1'b1;
          if (needs_esc(crc_q)) begin
            tx_byte_d = ESC;
            esc_d     = esc_code(crc_q);
            state_d   = S_CRC_ESC2;
          end else begin
            tx_byte_d = crc_q;
            state_d   = S_EOF;
          end
        end
      end
      S_CRC_ESC2: begin
        if (slot_free) begin
          tx_byte_d = esc_q;
          tx_vld_d  = 1'b1;
          state_d   = S_EOF;
        end
      end
      S_EOF: begin
        if (slot_free) begin
          tx_byte_d = SOF;
          tx_vld_d  = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        // EOF is never shared with the next SOF: wait for its acceptance first.
        if (tx_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tx_byte_q <= 8'h00;
      tx_vld_q  <= 1'b0;
      crc_q     <= CRC_INIT;
      cnt_q     <= 8'd0;
      esc_q     <= 8'h00;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
      tx_vld_q  <= tx_vld_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      esc_q     <= esc_d;
      last_q    <= last_d;
    end
  end

endmodule
